// File: rtl/divide_seq_f32.sv
// divide_seq_f32
// Issue/sequencing stage in front of the single-precision divider.
// Operand pairs arrive over a valid/ready stream and wait in a small FIFO.
// The FSM launches each pair into the divider by holding its active-high
// reset for one LAUNCH cycle, waits for rdy, then returns the quotient on a
// valid/ready result stream. Zero denominators bypass the divider. A stuck
// divider is cut off by a timeout that returns a quiet NaN.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_valid   request valid
//   in_ready   FIFO not full (registered)
//   in_num     numerator float
//   in_den     denominator float
//   div_rst    active-high reset/launch to the divider (registered)
//   div_num    numerator to the divider (registered, stable through WAIT)
//   div_den    denominator to the divider (registered, stable through WAIT)
//   div_rdy    divider result ready
//   div_quo    divider quotient, valid while div_rdy=1
//   out_valid  result valid
//   out_ready  result consumer ready
//   out_quo    quotient
//   out_dz     divide-by-zero flag for this result
//   out_to     timeout flag for this result
//
// Parameters
//   WIDTH   float width, only 32 is supported
//   DEPTH   input FIFO entries, power of two, >= 2
//   MAXCYC  maximum WAIT cycles before timeout, 2..255
//
// FSM states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | divider held in reset; pop the FIFO head when available
//   S_LAUNCH | operands latched, divider reset held one more cycle
//   S_WAIT   | divider running; count cycles, wait for rdy or timeout
//   S_DONE   | result presented; hold until out_valid && out_ready

module divide_seq_f32 #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 2,
    parameter int MAXCYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    output logic             div_rst,
    output logic [WIDTH-1:0] div_num,
    output logic [WIDTH-1:0] div_den,
    input  logic             div_rdy,
    input  logic [WIDTH-1:0] div_quo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quo,
    output logic             out_dz,
    output logic             out_to
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [7:0] CNT_LAST = 8'(MAXCYC - 1);
    localparam logic [WIDTH-1:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    // ---------------------------------------------------------------
    // Input FIFO
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] num_mem [DEPTH];
    logic [WIDTH-1:0] den_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_d;
    logic             avail;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head_num;
    logic [WIDTH-1:0] head_den;

    assign push     = in_valid && in_ready;
    assign head_num = num_mem[rd_ptr];
    assign head_den = den_mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + CW'(1);
        end else if (!push && pop) begin
            count_d = count - CW'(1);
        end
    end

    // avail is the registered copy of (count != 0), one cycle behind the
    // count. It can only be stale-high right after a pop, and a pop always
    // leaves IDLE for at least one cycle, so IDLE never pops an empty FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            avail    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_d;
            in_ready <= (count_d != CW'(DEPTH));
            avail    <= (count != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            num_mem[wr_ptr] <= in_num;
            den_mem[wr_ptr] <= in_den;
        end
    end

    // ---------------------------------------------------------------
    // Sequencing FSM
    // ---------------------------------------------------------------
    state_t           state;
    state_t           state_d;
    logic [7:0]       cnt;
    logic [7:0]       cnt_d;
    logic             div_rst_d;
    logic [WIDTH-1:0] div_num_d;
    logic [WIDTH-1:0] div_den_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_quo_d;
    logic             out_dz_d;
    logic             out_to_d;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        div_rst_d   = div_rst;
        div_num_d   = div_num;
        div_den_d   = div_den;
        out_valid_d = out_valid;
        out_quo_d   = out_quo;
        out_dz_d    = out_dz;
        out_to_d    = out_to;
        pop         = 1'b0;

        case (state)
            S_IDLE: begin
                div_rst_d = 1'b1;
                if (avail) begin
                    pop = 1'b1;
                    // +0.0 and -0.0 both count as zero; the divider is skipped.
                    if (head_den[WIDTH-2:0] == '0) begin
                        out_quo_d   = {head_num[WIDTH-1] ^ head_den[WIDTH-1], 8'hFF, 23'h0};
                        out_dz_d    = 1'b1;
                        out_to_d    = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        div_num_d = head_num;
                        div_den_d = head_den;
                        state_d   = S_LAUNCH;
                    end
                end
            end

            S_LAUNCH: begin
                // div_rst is still high during this cycle; it drops for WAIT.
                div_rst_d = 1'b0;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end

            S_WAIT: begin
                cnt_d = cnt + 8'd1;
                if (div_rdy) begin
                    out_quo_d   = div_quo;
                    out_dz_d    = 1'b0;
                    out_to_d    = 1'b0;
                    out_valid_d = 1'b1;
                    div_rst_d   = 1'b1;
                    state_d     = S_DONE;
                end else if (cnt == CNT_LAST) begin
                    out_quo_d   = QNAN;
                    out_dz_d    = 1'b0;
                    out_to_d    = 1'b1;
                    out_valid_d = 1'b1;
                    div_rst_d   = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                div_rst_d = 1'b1;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            div_rst   <= 1'b1;
            div_num   <= '0;
            div_den   <= '0;
            out_valid <= 1'b0;
            out_quo   <= '0;
            out_dz    <= 1'b0;
            out_to    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            div_rst   <= div_rst_d;
            div_num   <= div_num_d;
            div_den   <= div_den_d;
            out_valid <= out_valid_d;
            out_quo   <= out_quo_d;
            out_dz    <= out_dz_d;
            out_to    <= out_to_d;
        end
    end

endmodule

// File: tb/tb_divide_seq_f32.sv
// Testbench for divide_seq_f32 with a behavioural divider stub.
module tb_divide_seq_f32;

    typedef struct {
        logic [31:0] quo;
        logic        dz;
        logic        to;
    } exp_t;

    typedef struct {
        logic [31:0] num;
        logic [31:0] den;
        int          dly;
        logic [31:0] quo;
        logic        dz;
        logic        to;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_num;
    logic [31:0] in_den;
    logic        div_rst;
    logic [31:0] div_num;
    logic [31:0] div_den;
    logic        div_rdy;
    logic [31:0] div_quo;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_quo;
    logic        out_dz;
    logic        out_to;

    int   n_vec = 0;
    int   n_err = 0;
    int   stub_delay = 0;
    int   scnt = 0;
    bit   mon_en = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vt[10];

    always #5 clk = ~clk;

    divide_seq_f32 #(.WIDTH(32), .DEPTH(2), .MAXCYC(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_den    (in_den),
        .div_rst   (div_rst),
        .div_num   (div_num),
        .div_den   (div_den),
        .div_rdy   (div_rdy),
        .div_quo   (div_quo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quo   (out_quo),
        .out_dz    (out_dz),
        .out_to    (out_to)
    );

    // Divider stand-in: a fixed answer for 6.0/3.0, otherwise num^den.
    function automatic logic [31:0] stub_quo_f(input logic [31:0] n, input logic [31:0] d);
        if (n == 32'h40C00000 && d == 32'h40400000) return 32'h40000000;
        return n ^ d;
    endfunction

    function automatic exp_t exp_of(input logic [31:0] n, input logic [31:0] d, input int dly);
        exp_t e;
        if (d[30:0] == 31'h0) begin
            e.quo = {n[31] ^ d[31], 8'hFF, 23'h0};
            e.dz  = 1'b1;
            e.to  = 1'b0;
        end else if (dly == 0 || dly > 64) begin
            e.quo = 32'h7FC00000;
            e.dz  = 1'b0;
            e.to  = 1'b1;
        end else begin
            e.quo = stub_quo_f(n, d);
            e.dz  = 1'b0;
            e.to  = 1'b0;
        end
        return e;
    endfunction

    // rdy rises in the stub_delay-th cycle with div_rst low (0 = never).
    always @(negedge clk) begin
        if (div_rst !== 1'b0) begin
            scnt    = 0;
            div_rdy = 1'b0;
        end else begin
            if (scnt < 1000) scnt++;
            div_rdy = (stub_delay != 0) && (scnt >= stub_delay);
        end
        div_quo = stub_quo_f(div_num, div_den);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard: every completed result handshake pops one expectation.
    always @(negedge clk) begin
        if (mon_en && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got quo=%h dz=%b to=%b, required none",
                         out_quo, out_dz, out_to);
            end else begin
                mon_e = sb_q.pop_front();
                check("result_quo", out_quo, mon_e.quo);
                check("result_dz", 32'(out_dz), 32'(mon_e.dz));
                check("result_to", 32'(out_to), 32'(mon_e.to));
            end
        end
    end

    task automatic send(input logic [31:0] n, input logic [31:0] d, input exp_t e);
        int b = 0;
        while (in_ready !== 1'b1 && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        if (in_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL in_ready_wait: got %b, required 1", in_ready);
        end
        in_valid = 1'b1;
        in_num   = n;
        in_den   = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic run_one(input vec_t v);
        exp_t e;
        int   lat = 0;
        bit   got = 1'b0;
        bit   saw_fall = 1'b0;
        bit   stable = 1'b1;
        stub_delay = v.dly;
        out_ready  = 1'b1;
        e.quo = v.quo;
        e.dz  = v.dz;
        e.to  = v.to;
        send(v.num, v.den, e);
        while (!got && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (div_rst === 1'b0) begin
                saw_fall = 1'b1;
                if (div_num !== v.num || div_den !== v.den) stable = 1'b0;
            end
            if (!v.dz && lat == 2) begin
                check("launch_div_rst", 32'(div_rst), 32'd1);
                check("launch_div_num", div_num, v.num);
                check("launch_div_den", div_den, v.den);
            end
            if (!v.dz && lat == 3) check("wait_div_rst", 32'(div_rst), 32'd0);
            if (out_valid === 1'b1) got = 1'b1;
        end
        check("latency", 32'(lat), 32'(v.lat));
        check("div_rst_fell", 32'(saw_fall), 32'(!v.dz));
        check("operands_stable", 32'(stable), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin : main
        logic [31:0] sn [6];
        logic [31:0] sd [6];
        int b;

        vt[0] = '{32'h40C00000, 32'h40400000, 3,  32'h40000000, 1'b0, 1'b0, 6};
        vt[1] = '{32'hBF800000, 32'h00000000, 3,  32'hFF800000, 1'b1, 1'b0, 2};
        vt[2] = '{32'h3F800000, 32'h80000000, 3,  32'hFF800000, 1'b1, 1'b0, 2};
        vt[3] = '{32'h7F800000, 32'h00000000, 3,  32'h7F800000, 1'b1, 1'b0, 2};
        vt[4] = '{32'hBF800000, 32'h80000000, 3,  32'h7F800000, 1'b1, 1'b0, 2};
        vt[5] = '{32'h3F800000, 32'h40000000, 1,  32'h7F800000, 1'b0, 1'b0, 4};
        vt[6] = '{32'h7FC00001, 32'h40000000, 2,  32'h3FC00001, 1'b0, 1'b0, 5};
        vt[7] = '{32'h40000000, 32'h3F800000, 0,  32'h7FC00000, 1'b0, 1'b1, 67};
        vt[8] = '{32'h40400000, 32'h40800000, 64, 32'h00C00000, 1'b0, 1'b0, 67};
        vt[9] = '{32'h41000000, 32'h40000000, 65, 32'h7FC00000, 1'b0, 1'b1, 67};

        sn = '{32'h40800000, 32'h3F800000, 32'h40000000, 32'hC0000000, 32'h41200000, 32'h3F000000};
        sd = '{32'h40000000, 32'h00000000, 32'h40400000, 32'h80000000, 32'h40A00000, 32'h3E800000};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_num    = '0;
        in_den    = '0;
        out_ready = 1'b0;
        div_rdy   = 1'b0;
        div_quo   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_div_rst", 32'(div_rst), 32'd1);
        check("rst_div_num", div_num, 32'h0);
        check("rst_div_den", div_den, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_quo", out_quo, 32'h0);
        check("rst_out_dz", 32'(out_dz), 32'd0);
        check("rst_out_to", 32'(out_to), 32'd0);
        @(posedge clk); #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Single requests: normal, divide-by-zero, NaN, timeout, coincident rdy/timeout
        for (int i = 0; i < 10; i++) run_one(vt[i]);

        // Backpressure: three back-to-back requests with the consumer stalled
        out_ready  = 1'b0;
        stub_delay = 2;
        send(32'h40800000, 32'h40000000, exp_of(32'h40800000, 32'h40000000, 2));
        send(32'h3F800000, 32'h80000000, exp_of(32'h3F800000, 32'h80000000, 2));
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        send(32'h40000000, 32'h3F800000, exp_of(32'h40000000, 32'h3F800000, 2));
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_held", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_quo_head", out_quo, 32'h00800000);
        @(posedge clk); #1;
        out_ready = 1'b1;
        b = 0;
        while (sb_q.size() != 0 && b < 500) begin
            @(posedge clk); #1;
            b++;
        end
        check("bp_drain", 32'(sb_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_after", 32'(in_ready), 32'd1);

        // Streaming with push and pop overlapping
        stub_delay = 1;
        for (int i = 0; i < 6; i++) send(sn[i], sd[i], exp_of(sn[i], sd[i], 1));
        b = 0;
        while (sb_q.size() != 0 && b < 500) begin
            @(posedge clk); #1;
            b++;
        end
        check("stream_drain", 32'(sb_q.size()), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("stream_in_ready", 32'(in_ready), 32'd1);
        run_one(vt[2]);

        // Reset in the middle of WAIT, with a second request queued
        stub_delay = 0;
        send(32'h40000000, 32'h40400000, exp_of(32'h40000000, 32'h40400000, 0));
        repeat (8) @(posedge clk);
        #1;
        send(32'h3F800000, 32'h40000000, exp_of(32'h3F800000, 32'h40000000, 0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_div_rst", 32'(div_rst), 32'd1);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_div_num", div_num, 32'h0);
        repeat (80) @(posedge clk);
        @(negedge clk);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_div_rst", 32'(div_rst), 32'd1);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        run_one(vt[1]);
        run_one(vt[0]);

        repeat (5) @(posedge clk);
        check("final_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
